// File: rtl/axis_type.svh
// AXI-Stream forward (mosi) and return (miso) channel types plus the header TID code.
// Included inside a module body; relies on the enclosing DATA/ID/DEST/USER_WIDTH parameters.
typedef struct packed {
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;
  logic                    tvalid;
} axis_mosi_t;

typedef struct packed {
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tready;
} axis_miso_t;

localparam logic [ID_WIDTH-1:0] ROUTING_HEADER = ID_WIDTH'(1);

// File: rtl/arbiter_packet.sv
// Packet-locked round-robin arbiter merging INPUT_NUMBER AXI-Stream sources into one port.
// Optional PMU counters are built only when ARBITER_PMU_EN is defined.
module arbiter_packet #(
  parameter int DATA_WIDTH         = 32,
  parameter int ID_WIDTH           = 4,
  parameter int DEST_WIDTH         = 4,
  parameter int USER_WIDTH         = 4,
  parameter int INPUT_NUMBER       = 5,
  parameter int INPUT_NUMBER_WIDTH = $clog2(INPUT_NUMBER),
  parameter int PMU_WIDTH          = 32,
  localparam int MOSI_WIDTH = DATA_WIDTH + 2 * (DATA_WIDTH / 8) + ID_WIDTH + DEST_WIDTH
                              + USER_WIDTH + 2,
  localparam int MISO_WIDTH = DATA_WIDTH + 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic [INPUT_NUMBER-1:0][MOSI_WIDTH-1:0] in_mosi_i,
  output logic [INPUT_NUMBER-1:0][MISO_WIDTH-1:0] in_miso_o,
  output logic [MOSI_WIDTH-1:0]                  out_mosi_o,
  input  logic [MISO_WIDTH-1:0]                  out_miso_i,
  output logic [INPUT_NUMBER_WIDTH-1:0]          current_grant_o,
  output logic                                   busy_o,
  output logic [PMU_WIDTH-1:0]                   pmu_packets_o,
  output logic [PMU_WIDTH-1:0]                   pmu_stall_o
);

  `include "axis_type.svh"

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                        state;
  logic [INPUT_NUMBER_WIDTH-1:0] grant;
  logic [INPUT_NUMBER_WIDTH-1:0] next_grant;
  logic                          found;
  logic [INPUT_NUMBER-1:0]       header_req;
  logic                          last_hs;

  axis_mosi_t in_mosi [INPUT_NUMBER];
  axis_mosi_t out_mosi;
  axis_miso_t out_miso;

  assign out_miso = out_miso_i;

  always_comb begin
    for (int i = 0; i < INPUT_NUMBER; i++) begin
      in_mosi[i]    = in_mosi_i[i];
      header_req[i] = in_mosi[i].tvalid && (in_mosi[i].tid == ROUTING_HEADER);
    end
  end

  // Rotating search starting one past the previous winner, so the last winner is
  // always considered last.
  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first, so no path through the block leaves a value held (no latch).
  always_comb begin
    found      = 1'b0;
    next_grant = grant;
    for (int k = 1; k <= INPUT_NUMBER; k++) begin
      if (!found &&
          header_req[INPUT_NUMBER_WIDTH'((int'(grant) + k) % INPUT_NUMBER)]) begin
        found      = 1'b1;
        next_grant = INPUT_NUMBER_WIDTH'((int'(grant) + k) % INPUT_NUMBER);
      end
    end
  end

  // Zero-latency data path while locked; everything is silenced while idle.
  always_comb begin
    out_mosi  = '0;
    in_miso_o = '0;
    if (state == LOCKED) begin
      out_mosi         = in_mosi[grant];
      in_miso_o[grant] = out_miso_i;
    end
  end

  assign out_mosi_o = out_mosi;
  assign last_hs    = (state == LOCKED) && out_mosi.tvalid && out_miso.tready
                      && out_mosi.tlast;

  // NOTE: sequential state uses non-blocking '<=' so every flop samples values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      grant <= INPUT_NUMBER_WIDTH'(INPUT_NUMBER - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= next_grant;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          // grant is kept on release so the winner drops to lowest priority.
          if (last_hs) state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o          = (state == LOCKED);
  assign current_grant_o = grant;

`ifdef ARBITER_PMU_EN
  logic                 stall;
  logic [PMU_WIDTH-1:0] pkt_cnt;
  logic [PMU_WIDTH-1:0] stall_cnt;

  assign stall = (state == LOCKED) && out_mosi.tvalid && !out_miso.tready;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pkt_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (last_hs) pkt_cnt <= pkt_cnt + PMU_WIDTH'(1);
      if (stall)   stall_cnt <= stall_cnt + PMU_WIDTH'(1);
    end
  end

  assign pmu_packets_o = pkt_cnt;
  assign pmu_stall_o   = stall_cnt;
`else
  assign pmu_packets_o = '0;
  assign pmu_stall_o   = '0;
`endif

endmodule

// File: tb/tb_arbiter_packet.sv
// Table-driven bench for arbiter_packet: one record per clock cycle with hand-computed
// grant, busy, per-source TREADY, output flit and PMU expectations.
module tb_arbiter_packet;

  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 4;
  localparam int DEST_WIDTH = 4;
  localparam int USER_WIDTH = 4;
  localparam int N          = 5;
  localparam int PMU_WIDTH  = 32;
  localparam logic [3:0] HDR_TID  = 4'd1;
  localparam logic [3:0] DATA_TID = 4'd5;
`ifdef ARBITER_PMU_EN
  localparam bit PMU_EN = 1'b1;
`else
  localparam bit PMU_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic [3:0]  tkeep;
    logic        tlast;
    logic [3:0]  tid;
    logic [3:0]  tdest;
    logic [3:0]  tuser;
    logic        tvalid;
  } axis_mosi_t;

  typedef struct packed {
    logic [31:0] tdata;
    logic        tready;
  } axis_miso_t;

  typedef struct {
    logic       rst_n;
    logic [4:0] vld;
    logic [4:0] hdr;
    logic [4:0] last;
    logic [7:0] seq;
    logic       rdy;
    logic       e_busy;
    logic [2:0] e_grant;
    logic       e_vld;
    logic [4:0] e_trdy;
    int         e_pkts;
    int         e_stall;
  } vec_t;

  logic                clk_i = 1'b0;
  logic                rst_n_i = 1'b0;
  axis_mosi_t [N-1:0]  in_mosi = '0;
  axis_miso_t [N-1:0]  in_miso;
  axis_mosi_t          out_mosi;
  axis_miso_t          out_miso = '0;
  logic [2:0]          current_grant;
  logic                busy;
  logic [PMU_WIDTH-1:0] pmu_packets;
  logic [PMU_WIDTH-1:0] pmu_stall;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vq[$];

  arbiter_packet #(
    .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH), .DEST_WIDTH(DEST_WIDTH),
    .USER_WIDTH(USER_WIDTH), .INPUT_NUMBER(N), .PMU_WIDTH(PMU_WIDTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .in_mosi_i      (in_mosi),
    .in_miso_o      (in_miso),
    .out_mosi_o     (out_mosi),
    .out_miso_i     (out_miso),
    .current_grant_o(current_grant),
    .busy_o         (busy),
    .pmu_packets_o  (pmu_packets),
    .pmu_stall_o    (pmu_stall)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mk_data(input int src, input logic [7:0] seq);
    return 32'hC0DE_0000 | (32'(src) << 8) | 32'(seq);
  endfunction

  function automatic vec_t mk(input logic rst_n, input logic [4:0] vld, input logic [4:0] hdr,
                              input logic [4:0] last, input logic [7:0] seq, input logic rdy,
                              input logic e_busy, input logic [2:0] e_grant, input logic e_vld,
                              input logic [4:0] e_trdy, input int e_pkts, input int e_stall);
    vec_t v;
    v.rst_n = rst_n; v.vld = vld; v.hdr = hdr; v.last = last; v.seq = seq; v.rdy = rdy;
    v.e_busy = e_busy; v.e_grant = e_grant; v.e_vld = e_vld; v.e_trdy = e_trdy;
    v.e_pkts = e_pkts; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic check(input string name, input int vec, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, vec, act, exp);
  endtask

  task automatic apply(input vec_t v);
    rst_n_i = v.rst_n;
    out_miso.tready = v.rdy;
    out_miso.tdata  = 32'hBEEF_0000 | 32'(v.seq);
    for (int i = 0; i < N; i++) begin
      in_mosi[i].tdata  = mk_data(i, v.seq);
      in_mosi[i].tstrb  = '1;
      in_mosi[i].tkeep  = '1;
      in_mosi[i].tlast  = v.last[i];
      in_mosi[i].tid    = v.hdr[i] ? HDR_TID : DATA_TID;
      in_mosi[i].tdest  = 4'(i);
      in_mosi[i].tuser  = '0;
      in_mosi[i].tvalid = v.vld[i];
    end
  endtask

  task automatic compare(input vec_t v, input int k);
    logic [4:0] trdy;
    for (int i = 0; i < N; i++) trdy[i] = in_miso[i].tready;
    check("busy", k, 64'(busy), 64'(v.e_busy));
    check("grant", k, 64'(current_grant), 64'(v.e_grant));
    check("in_tready", k, 64'(trdy), 64'(v.e_trdy));
    check("pmu_packets", k, 64'(pmu_packets), PMU_EN ? 64'(v.e_pkts) : 64'd0);
    check("pmu_stall", k, 64'(pmu_stall), PMU_EN ? 64'(v.e_stall) : 64'd0);
    if (v.e_busy) begin
      check("out_tvalid", k, 64'(out_mosi.tvalid), 64'(v.e_vld));
      check("out_tdata", k, 64'(out_mosi.tdata), 64'(mk_data(int'(v.e_grant), v.seq)));
      check("back_tdata", k, 64'(in_miso[v.e_grant].tdata), 64'(32'hBEEF_0000 | 32'(v.seq)));
    end else begin
      check("out_idle_zero", k, 64'(out_mosi), 64'd0);
    end
  endtask

  initial begin
    // rst vld hdr last seq rdy | busy grant vld trdy pkts stall
    // Reset and a single 3-flit packet on input 0.
    vq.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 4, 0, 5'b00000, 0, 0));
    vq.push_back(mk(1, 5'b00001, 5'b00001, 5'b00000, 1, 1, 0, 4, 0, 5'b00000, 0, 0));
    vq.push_back(mk(1, 5'b00001, 5'b00001, 5'b00000, 1, 1, 1, 0, 1, 5'b00001, 0, 0));
    vq.push_back(mk(1, 5'b00001, 5'b00000, 5'b00000, 2, 1, 1, 0, 1, 5'b00001, 0, 0));
    vq.push_back(mk(1, 5'b00001, 5'b00000, 5'b00001, 3, 1, 1, 0, 1, 5'b00001, 0, 0));
    vq.push_back(mk(1, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0, 0, 0, 5'b00000, 1, 0));
    // Re-reset (grant back to 4), then inputs 1, 2, 4 contend; 1 re-requests later.
    vq.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0, 4, 0, 5'b00000, 0, 0));
    vq.push_back(mk(1, 5'b10110, 5'b10110, 5'b00000, 1, 1, 0, 4, 0, 5'b00000, 0, 0));
    vq.push_back(mk(1, 5'b10110, 5'b10110, 5'b00000, 1, 1, 1, 1, 1, 5'b00010, 0, 0));
    vq.push_back(mk(1, 5'b10110, 5'b10100, 5'b00010, 2, 1, 1, 1, 1, 5'b00010, 0, 0));
    vq.push_back(mk(1, 5'b10100, 5'b10100, 5'b00000, 1, 1, 0, 1, 0, 5'b00000, 1, 0));
    vq.push_back(mk(1, 5'b10100, 5'b10100, 5'b00000, 1, 1, 1, 2, 1, 5'b00100, 1, 0));
    vq.push_back(mk(1, 5'b10100, 5'b10000, 5'b00100, 2, 1, 1, 2, 1, 5'b00100, 1, 0));
    vq.push_back(mk(1, 5'b10010, 5'b10010, 5'b00000, 1, 1, 0, 2, 0, 5'b00000, 2, 0));
    vq.push_back(mk(1, 5'b10010, 5'b10010, 5'b00000, 1, 1, 1, 4, 1, 5'b10000, 2, 0));
    vq.push_back(mk(1, 5'b10010, 5'b00010, 5'b10000, 2, 1, 1, 4, 1, 5'b10000, 2, 0));
    vq.push_back(mk(1, 5'b00010, 5'b00010, 5'b00010, 1, 1, 0, 4, 0, 5'b00000, 3, 0));
    vq.push_back(mk(1, 5'b00010, 5'b00010, 5'b00010, 1, 1, 1, 1, 1, 5'b00010, 3, 0));
    vq.push_back(mk(1, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0, 1, 0, 5'b00000, 4, 0));
    // Backpressure: input 3 locked, TREADY low 5 cycles, input 0 waiting.
    vq.push_back(mk(1, 5'b01001, 5'b01001, 5'b00000, 1, 1, 0, 1, 0, 5'b00000, 4, 0));
    vq.push_back(mk(1, 5'b01001, 5'b01001, 5'b00000, 1, 1, 1, 3, 1, 5'b01000, 4, 0));
    for (int s = 0; s < 5; s++)
      vq.push_back(mk(1, 5'b01001, 5'b00001, 5'b00000, 2, 0, 1, 3, 1, 5'b00000, 4, s));
    vq.push_back(mk(1, 5'b01001, 5'b00001, 5'b00000, 2, 1, 1, 3, 1, 5'b01000, 4, 5));
    vq.push_back(mk(1, 5'b01001, 5'b00001, 5'b01000, 3, 1, 1, 3, 1, 5'b01000, 4, 5));
    // Single-flit packets on inputs 0 and 1 alternate, two cycles each.
    vq.push_back(mk(1, 5'b00011, 5'b00011, 5'b00011, 1, 1, 0, 3, 0, 5'b00000, 5, 5));
    vq.push_back(mk(1, 5'b00011, 5'b00011, 5'b00011, 1, 1, 1, 0, 1, 5'b00001, 5, 5));
    vq.push_back(mk(1, 5'b00011, 5'b00011, 5'b00011, 1, 1, 0, 0, 0, 5'b00000, 6, 5));
    vq.push_back(mk(1, 5'b00011, 5'b00011, 5'b00011, 1, 1, 1, 1, 1, 5'b00010, 6, 5));
    vq.push_back(mk(1, 5'b00011, 5'b00011, 5'b00011, 1, 1, 0, 1, 0, 5'b00000, 7, 5));
    vq.push_back(mk(1, 5'b00011, 5'b00011, 5'b00011, 1, 1, 1, 0, 1, 5'b00001, 7, 5));
    vq.push_back(mk(1, 5'b00010, 5'b00010, 5'b00010, 1, 1, 0, 0, 0, 5'b00000, 8, 5));
    vq.push_back(mk(1, 5'b00010, 5'b00010, 5'b00010, 1, 1, 1, 1, 1, 5'b00010, 8, 5));
    vq.push_back(mk(1, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0, 1, 0, 5'b00000, 9, 5));
    // Non-header TID on input 2 is ignored; header on 0 wins; TVALID drops mid-packet.
    vq.push_back(mk(1, 5'b00100, 5'b00000, 5'b00000, 1, 1, 0, 1, 0, 5'b00000, 9, 5));
    vq.push_back(mk(1, 5'b00100, 5'b00000, 5'b00000, 1, 1, 0, 1, 0, 5'b00000, 9, 5));
    vq.push_back(mk(1, 5'b00101, 5'b00001, 5'b00000, 1, 1, 0, 1, 0, 5'b00000, 9, 5));
    vq.push_back(mk(1, 5'b00101, 5'b00001, 5'b00000, 1, 1, 1, 0, 1, 5'b00001, 9, 5));
    vq.push_back(mk(1, 5'b01100, 5'b01000, 5'b00000, 2, 1, 1, 0, 0, 5'b00001, 9, 5));
    vq.push_back(mk(1, 5'b01101, 5'b01000, 5'b00001, 2, 1, 1, 0, 1, 5'b00001, 9, 5));
    vq.push_back(mk(1, 5'b01100, 5'b01000, 5'b00000, 1, 1, 0, 0, 0, 5'b00000, 10, 5));
    // Reset mid-packet on input 3.
    vq.push_back(mk(1, 5'b01000, 5'b01000, 5'b00000, 1, 1, 1, 3, 1, 5'b01000, 10, 5));
    vq.push_back(mk(1, 5'b01000, 5'b00000, 5'b00000, 2, 1, 1, 3, 1, 5'b01000, 10, 5));
    vq.push_back(mk(0, 5'b01000, 5'b00000, 5'b00000, 3, 1, 0, 4, 0, 5'b00000, 0, 0));
    vq.push_back(mk(1, 5'b00000, 5'b00000, 5'b00000, 0, 1, 0, 4, 0, 5'b00000, 0, 0));

    apply(vq[0]);
    for (int k = 0; k < vq.size(); k++) begin
      if (k != 0) begin
        @(posedge clk_i);
        #1;
        apply(vq[k]);
      end
      @(negedge clk_i);
      compare(vq[k], k);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
